mux128_rr_arbiter: RTL

- Round-robin arbiter and sequencer for the shared 128-to-1 n-bit read mux.
- Lets R requesters share the single mux. It picks one requester per cycle, drives the mux select from a register, and captures the mux output one cycle later. The captured data is returned to the winning requester with a one-hot valid.
- Sits between requester blocks and the mux instance. The mux itself is instantiated by the parent, not inside this block.

---
 rtl/mux128_rr_arbiter_pkg.sv | 14 +
 rtl/mux128_rr_arbiter_if.sv | 25 ++
 rtl/mux128_rr_arbiter_rr_pick.sv | 32 +++
 rtl/mux128_rr_arbiter.sv | 69 ++++++
 4 files changed

// File: rtl/mux128_rr_arbiter_pkg.sv
// Shared constants and helpers for the round-robin arbiter in front of the 128-entry read mux.
package mux_arb_pkg;

   localparam int ADDR_W = 7;
   localparam int DEPTH  = 2 ** ADDR_W;

   // Large enough to hold a requester id for up to 8 requesters
   typedef logic [2:0] req_id_t;

   function automatic logic [7:0] onehot(input req_id_t id);
      return 8'b1 << id;
   endfunction

endpackage

// File: rtl/mux128_rr_arbiter_if.sv
// Requester/mux-facing bundle of the arbiter; master is the parent side, slave is the arbiter.
interface mux128_rr_arbiter_if #(
   parameter int n       = 4,
   parameter int R       = 4,
   parameter int address = 7
);
   logic [R-1:0]              req_i;
   logic [R-1:0][address-1:0] addr_i;
   logic [R-1:0]              gnt_o;
   logic [address-1:0]        sel_o;
   logic [n-1:0]              mux_data_i;
   logic [R-1:0]              rsp_valid_o;
   logic [n-1:0]              rsp_data_o;
   logic                      busy_o;

   modport master (
      output req_i, addr_i, mux_data_i,
      input  gnt_o, sel_o, rsp_valid_o, rsp_data_o, busy_o
   );

   modport slave (
      input  req_i, addr_i, mux_data_i,
      output gnt_o, sel_o, rsp_valid_o, rsp_data_o, busy_o
   );
endinterface

// File: rtl/mux128_rr_arbiter_rr_pick.sv
// Combinational rotate-priority picker: first requester at or after ptr, wrapping at R.
module rr_pick #(
   parameter int R    = 4,
   parameter int ID_W = $clog2(R)
) (
   input  logic [R-1:0]    req,
   input  logic [ID_W-1:0] ptr,
   output logic            any,
   output logic [ID_W-1:0] winner
);
   logic [ID_W-1:0] idx [R];
   logic [R-1:0]    req_rot;

   // Explicit wrap so non-power-of-two R never indexes past the last requester
   for (genvar gi = 0; gi < R; gi++) begin : gen_rot
      logic [ID_W:0] sum;
      assign sum         = {1'b0, ptr} + (ID_W+1)'(gi);
      assign idx[gi]     = (sum >= (ID_W+1)'(R)) ? ID_W'(sum - (ID_W+1)'(R)) : ID_W'(sum);
      assign req_rot[gi] = req[idx[gi]];
   end

   always_comb begin
      any    = 1'b0;
      winner = '0;
      for (int i = R - 1; i >= 0; i--) begin
         if (req_rot[i]) begin
            any    = 1'b1;
            winner = idx[i];
         end
      end
   end
endmodule

// File: rtl/mux128_rr_arbiter.sv
// Two-stage arbiter: stage A grants and drives the mux select, stage B captures the mux output.
module mux128_rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter int n       = 4,
   parameter int R       = 4,
   parameter int address = ADDR_W
) (
   input  logic                clk_i,
   input  logic                rst_i,
   mux128_rr_arbiter_if.slave  bus
);
   localparam int ID_W = $clog2(R);

   logic [ID_W-1:0]    ptr_reg;
   logic               a_valid_reg;
   logic [ID_W-1:0]    a_id_reg;
   logic [R-1:0]       gnt_reg;
   logic [address-1:0] sel_reg;
   logic [R-1:0]       rsp_valid_reg;
   logic [n-1:0]       rsp_data_reg;

   logic            win_any;
   logic [ID_W-1:0] win_id;

   rr_pick #(.R(R), .ID_W(ID_W)) u_pick (
      .req    (bus.req_i),
      .ptr    (ptr_reg),
      .any    (win_any),
      .winner (win_id)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ptr_reg       <= '0;
         a_valid_reg   <= 1'b0;
         a_id_reg      <= '0;
         gnt_reg       <= '0;
         sel_reg       <= '0;
         rsp_valid_reg <= '0;
         rsp_data_reg  <= '0;
      end else begin
         // Only the winner's address is sampled, so X on idle slots cannot reach sel
         if (win_any) begin
            gnt_reg     <= R'(onehot(req_id_t'(win_id)));
            sel_reg     <= bus.addr_i[win_id];
            a_valid_reg <= 1'b1;
            a_id_reg    <= win_id;
            ptr_reg     <= (win_id == ID_W'(R - 1)) ? '0 : win_id + 1'b1;
         end else begin
            gnt_reg     <= '0;
            a_valid_reg <= 1'b0;
         end

         if (a_valid_reg) begin
            rsp_data_reg  <= bus.mux_data_i;
            rsp_valid_reg <= R'(onehot(req_id_t'(a_id_reg)));
         end else begin
            rsp_valid_reg <= '0;
         end
      end
   end

   assign bus.gnt_o       = gnt_reg;
   assign bus.sel_o       = sel_reg;
   assign bus.rsp_valid_o = rsp_valid_reg;
   assign bus.rsp_data_o  = rsp_data_reg;
   assign bus.busy_o      = a_valid_reg | (|rsp_valid_reg);
endmodule
